lcd_bus_decoder: RTL and testbench

LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

---
 rtl/lcd_bus_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_decoder.sv
// LCD parallel-bus command/data decoder.
// Detects write strobes, decodes display commands, collects column/page
// window parameters and assembles RGB565 pixels with a window-wrapping pointer.
module lcd_bus_decoder (
    input  logic        hwclk,
    input  logic        rst,
    input  logic        dcx,
    input  logic        wr,
    input  logic [7:0]  D,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        disp_on,
    output logic        sleep_out,
    output logic        param_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CASET_P = 3'd1,
        ST_PASET_P = 3'd2,
        ST_RAM_HI  = 3'd3,
        ST_RAM_LO  = 3'd4,
        ST_IGNORE  = 3'd5
    } state_t;

    localparam logic [15:0] SC_DEF = 16'd0;
    localparam logic [15:0] EC_DEF = 16'd239;
    localparam logic [15:0] SP_DEF = 16'd0;
    localparam logic [15:0] EP_DEF = 16'd319;

    state_t      state_q, state_d;
    logic        wr_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] par_q, par_d;      // start hi, start lo, end hi
    logic [7:0]  hi_q, hi_d;        // first byte of a pixel
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_data_q, pix_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        disp_on_q, disp_on_d, sleep_out_q, sleep_out_d;
    logic        param_err_q, param_err_d;

    logic        byte_ev_s;
    logic [15:0] win_start_s, win_end_s;

    assign byte_ev_s   = wr & ~wr_q;
    assign win_start_s = par_q[23:8];
    assign win_end_s   = {par_q[7:0], D};

    // Next-state, parameter collection, pixel assembly and pointer advance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        hi_d        = hi_q;
        sc_d        = sc_q;
        ec_d        = ec_q;
        sp_d        = sp_q;
        ep_d        = ep_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_valid_d = 1'b0;
        cmd_valid_d = 1'b0;
        param_err_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_data_d  = pix_data_q;
        cmd_code_d  = cmd_code_q;
        disp_on_d   = disp_on_q;
        sleep_out_d = sleep_out_q;

        if (byte_ev_s && !dcx) begin
            // A command always wins: partial parameters and odd pixel bytes are dropped.
            cmd_valid_d = 1'b1;
            cmd_code_d  = D;
            cnt_d       = 2'd0;
            par_d       = 24'd0;
            hi_d        = 8'd0;
            case (D)
                8'h2A: state_d = ST_CASET_P;
                8'h2B: state_d = ST_PASET_P;
                8'h2C: begin
                    state_d = ST_RAM_HI;
                    x_d     = sc_q;
                    y_d     = sp_q;
                end
                8'h01: begin
                    sc_d        = SC_DEF;
                    ec_d        = EC_DEF;
                    sp_d        = SP_DEF;
                    ep_d        = EP_DEF;
                    disp_on_d   = 1'b0;
                    sleep_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                8'h11: begin
                    sleep_out_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                8'h10: begin
                    sleep_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                8'h29: begin
                    disp_on_d = 1'b1;
                    state_d   = ST_IDLE;
                end
                8'h28: begin
                    disp_on_d = 1'b0;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IGNORE;
            endcase
        end else if (byte_ev_s) begin
            case (state_q)
                ST_CASET_P, ST_PASET_P: begin
                    if (cnt_q == 2'd3) begin
                        // Window is committed only as a whole, and only if ordered.
                        if (win_start_s > win_end_s) begin
                            param_err_d = 1'b1;
                        end else if (state_q == ST_CASET_P) begin
                            sc_d = win_start_s;
                            ec_d = win_end_s;
                        end else begin
                            sp_d = win_start_s;
                            ep_d = win_end_s;
                        end
                        cnt_d   = 2'd0;
                        state_d = ST_IGNORE;
                    end else begin
                        case (cnt_q)
                            2'd0:    par_d[23:16] = D;
                            2'd1:    par_d[15:8]  = D;
                            default: par_d[7:0]   = D;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                ST_RAM_HI: begin
                    hi_d    = D;
                    state_d = ST_RAM_LO;
                end
                ST_RAM_LO: begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    pix_data_d  = {hi_q, D};
                    state_d     = ST_RAM_HI;
                    // Raster-order advance, wrapping inside the window.
                    if (x_q == ec_q) begin
                        x_d = sc_q;
                        if (y_q == ep_q) begin
                            y_d = sp_q;
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, strobe history and output registers with asynchronous reset.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            cnt_q       <= 2'd0;
            par_q       <= 24'd0;
            hi_q        <= 8'd0;
            sc_q        <= SC_DEF;
            ec_q        <= EC_DEF;
            sp_q        <= SP_DEF;
            ep_q        <= EP_DEF;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 16'd0;
            pix_y_q     <= 16'd0;
            pix_data_q  <= 16'd0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 8'd0;
            disp_on_q   <= 1'b0;
            sleep_out_q <= 1'b0;
            param_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            hi_q        <= hi_d;
            sc_q        <= sc_d;
            ec_q        <= ec_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_data_q  <= pix_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            disp_on_q   <= disp_on_d;
            sleep_out_q <= sleep_out_d;
            param_err_q <= param_err_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_data  = pix_data_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign disp_on   = disp_on_q;
    assign sleep_out = sleep_out_q;
    assign param_err = param_err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed self-checking bench for lcd_bus_decoder.
module tb_lcd_bus_decoder;

    logic        hwclk = 1'b0;
    logic        rst;
    logic        dcx;
    logic        wr;
    logic [7:0]  D;
    logic        pix_valid;
    logic [15:0] pix_x, pix_y, pix_data;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        disp_on, sleep_out, param_err;

    int checks = 0;
    int passes = 0;
    int pix_cnt = 0;

    // Values captured one step after the event edge, plus pix_valid just before it.
    logic        s_pv, s_pv_pre, s_cv, s_pe, s_don, s_slp;
    logic [15:0] s_px, s_py, s_pd;
    logic [7:0]  s_cc;

    lcd_bus_decoder dut (
        .hwclk(hwclk), .rst(rst), .dcx(dcx), .wr(wr), .D(D),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .disp_on(disp_on),
        .sleep_out(sleep_out), .param_err(param_err)
    );

    always #5 hwclk = ~hwclk;

    // Count pixel pulses, one sample per clock cycle.
    always @(negedge hwclk) if (pix_valid === 1'b1) pix_cnt = pix_cnt + 1;

    task automatic send(input logic dc, input logic [7:0] b);
        @(negedge hwclk);
        dcx = dc; D = b; wr = 1'b1;
        #1 s_pv_pre = pix_valid;
        @(posedge hwclk);
        #1;
        s_pv = pix_valid; s_px = pix_x; s_py = pix_y; s_pd = pix_data;
        s_cv = cmd_valid; s_cc = cmd_code; s_pe = param_err;
        s_don = disp_on; s_slp = sleep_out;
        @(negedge hwclk);
        wr = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passes++;
    endtask

    task automatic test_reset;
        checks++; if ({pix_valid, cmd_valid, param_err, disp_on, sleep_out} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {pix_valid, cmd_valid, param_err, disp_on, sleep_out}); else passes++;
        checks++; if ({pix_x, pix_y, pix_data} !== 48'd0) $display("FAIL reset_pix: got %h expected 0", {pix_x, pix_y, pix_data}); else passes++;
        checks++; if (cmd_code !== 8'h00) $display("FAIL reset_cmd_code: got %h expected 00", cmd_code); else passes++;
    endtask

    task automatic test_single_pixel;
        int c0;
        send(1'b0, 8'h2C);
        checks++; if ({s_cv, s_cc} !== {1'b1, 8'h2C}) $display("FAIL ramwr_cmd: got %b/%h expected 1/2c", s_cv, s_cc); else passes++;
        c0 = pix_cnt;
        send(1'b1, 8'hF8);
        checks++; if (s_pv !== 1'b0) $display("FAIL first_byte_no_pix: got %b expected 0", s_pv); else passes++;
        send(1'b1, 8'h00);
        checks++; if ({s_pv_pre, s_pv} !== 2'b01) $display("FAIL pix_latency: got %b expected 01", {s_pv_pre, s_pv}); else passes++;
        checks++; if ({s_pd, s_px, s_py} !== {16'hF800, 16'd0, 16'd0}) $display("FAIL pix_f800: got %h/%0d/%0d expected f800/0/0", s_pd, s_px, s_py); else passes++;
        repeat (2) @(negedge hwclk);
        checks++; if (pix_cnt - c0 !== 1) $display("FAIL pix_one_pulse: got %0d expected 1", pix_cnt - c0); else passes++;
    endtask

    task automatic test_param_err;
        send(1'b0, 8'h01);
        send(1'b0, 8'h2A);
        send(1'b1, 8'h00); send(1'b1, 8'd20); send(1'b1, 8'h00);
        checks++; if (s_pe !== 1'b0) $display("FAIL param_err_early: got %b expected 0", s_pe); else passes++;
        send(1'b1, 8'd10);
        checks++; if (s_pe !== 1'b1) $display("FAIL param_err_pulse: got %b expected 1", s_pe); else passes++;
        send(1'b1, 8'h33);
        checks++; if ({s_pe, s_pv} !== 2'b00) $display("FAIL extra_param_ignored: got %b expected 00", {s_pe, s_pv}); else passes++;
        send(1'b0, 8'h2C); send(1'b1, 8'h12); send(1'b1, 8'h34);
        checks++; if ({s_pv, s_px, s_py} !== {1'b1, 16'd0, 16'd0}) $display("FAIL window_kept: got %b/%0d/%0d expected 1/0/0", s_pv, s_px, s_py); else passes++;
    endtask

    task automatic test_window;
        logic [15:0] ex [5] = '{16'd10, 16'd11, 16'd10, 16'd11, 16'd10};
        logic [15:0] ey [5] = '{16'd5, 16'd5, 16'd6, 16'd6, 16'd5};
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'd10); send(1'b1, 8'h00); send(1'b1, 8'd11);
        checks++; if (s_pe !== 1'b0) $display("FAIL caset_ok: got %b expected 0", s_pe); else passes++;
        send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'd5); send(1'b1, 8'h00); send(1'b1, 8'd6);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'hA0 + 8'(i)); send(1'b1, 8'h50 + 8'(i));
            checks++;
            if ({s_pv, s_px, s_py, s_pd} !== {1'b1, ex[i], ey[i], 8'hA0 + 8'(i), 8'h50 + 8'(i)})
                $display("FAIL window_pix%0d: got %b/%0d/%0d/%h expected 1/%0d/%0d/%h", i, s_pv, s_px, s_py, s_pd, ex[i], ey[i], {8'hA0 + 8'(i), 8'h50 + 8'(i)});
            else passes++;
        end
    endtask

    task automatic test_abort;
        send(1'b0, 8'h01);
        send(1'b0, 8'h2C); send(1'b1, 8'hAB);
        send(1'b0, 8'h29);
        checks++; if ({s_pv, s_cv, s_cc, s_don} !== {1'b0, 1'b1, 8'h29, 1'b1}) $display("FAIL abort_cmd: got %b/%b/%h/%b expected 0/1/29/1", s_pv, s_cv, s_cc, s_don); else passes++;
        send(1'b0, 8'h2C); send(1'b1, 8'h12); send(1'b1, 8'h34);
        checks++; if ({s_pv, s_pd} !== {1'b1, 16'h1234}) $display("FAIL abort_odd_dropped: got %b/%h expected 1/1234", s_pv, s_pd); else passes++;
    endtask

    task automatic test_wr_held_and_reset;
        int c0;
        send(1'b0, 8'h2C);
        c0 = pix_cnt;
        @(negedge hwclk); dcx = 1'b1; D = 8'h55; wr = 1'b1;
        repeat (5) @(negedge hwclk);
        wr = 1'b0;
        checks++; if (pix_cnt - c0 !== 0) $display("FAIL wr_held_no_pix: got %0d expected 0", pix_cnt - c0); else passes++;
        send(1'b1, 8'h66);
        checks++; if ({s_pv, s_pd} !== {1'b1, 16'h5566}) $display("FAIL wr_held_one_byte: got %b/%h expected 1/5566", s_pv, s_pd); else passes++;
        send(1'b1, 8'h11); send(1'b1, 8'h22);
        chk("second_pix_x", s_px, 16'd1);
        send(1'b1, 8'h77);
        #2 rst = 1'b1;
        #1;
        test_reset;
        @(negedge hwclk); rst = 1'b0;
        send(1'b1, 8'h88); send(1'b1, 8'h99);
        checks++; if (pix_cnt - c0 !== 2) $display("FAIL post_reset_idle: got %0d expected 2", pix_cnt - c0); else passes++;
    endtask

    task automatic test_power;
        send(1'b0, 8'h11);
        checks++; if ({s_slp, s_don} !== 2'b10) $display("FAIL sleep_out_set: got %b expected 10", {s_slp, s_don}); else passes++;
        send(1'b0, 8'h29);
        checks++; if ({s_slp, s_don} !== 2'b11) $display("FAIL disp_on_set: got %b expected 11", {s_slp, s_don}); else passes++;
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'd1); send(1'b1, 8'h00); send(1'b1, 8'd2);
        send(1'b0, 8'h01);
        checks++; if ({s_slp, s_don, s_cc} !== {2'b00, 8'h01}) $display("FAIL swreset_flags: got %b/%h expected 00/01", {s_slp, s_don}, s_cc); else passes++;
        send(1'b0, 8'h2C);
        for (int i = 0; i < 241; i++) begin
            send(1'b1, 8'h00); send(1'b1, 8'(i));
            if (i == 239) chk("default_ec_x", s_px, 16'd239);
            if (i == 240) chk("default_wrap_y", {s_px[7:0], s_py[7:0]}, 16'h0001);
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; dcx = 1'b0; D = 8'h00;
        repeat (3) @(negedge hwclk);
        test_reset;
        rst = 1'b0;
        test_single_pixel;
        test_param_err;
        test_window;
        test_abort;
        test_wr_held_and_reset;
        test_power;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
